// File: rtl/dpram_bist_ctrl_if.sv
// Host and RAM-side signal bundle for dpram_bist_ctrl.
// slave = the controller, master = host plus RAM environment.
interface dpram_bist_ctrl_if #(
    parameter int DW = 16,
    parameter int AW = 10
);
    logic          rd;
    logic          wr;
    logic          it;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          done;
    logic          busy;
    logic          pass;
    logic          fail;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] ram_data;
    logic [AW-1:0] ram_wraddr;
    logic [AW-1:0] ram_rdaddr;
    logic          ram_we;
    logic [DW-1:0] ram_q;

    modport slave (
        input  rd, wr, it, addr, din, ram_q,
        output dout, done, busy, pass, fail, fail_addr,
        output ram_data, ram_wraddr, ram_rdaddr, ram_we
    );

    modport master (
        output rd, wr, it, addr, din, ram_q,
        input  dout, done, busy, pass, fail, fail_addr,
        input  ram_data, ram_wraddr, ram_rdaddr, ram_we
    );
endinterface

// File: rtl/dpram_bist_ctrl.sv
// Dual-port RAM controller: host read/write arbitration plus a
// two-pass march self-test (pattern, then inverted pattern).
module dpram_bist_ctrl #(
    parameter int DW     = 16,
    parameter int AW     = 10,
    parameter int RD_LAT = 1
) (
    input logic              clk,
    input logic              ar,
    dpram_bist_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, H_WR, H_RD, T_WR1, T_RD1, T_WR2, T_RD2, T_END
    } state_t;

    localparam logic [AW-1:0] LAST = '1;

    state_t        state_q;
    logic [DW-1:0] dout_q;
    logic [DW-1:0] ram_data_q;
    logic [AW-1:0] wraddr_q;
    logic [AW-1:0] rdaddr_q;
    logic [AW-1:0] fail_addr_q;
    logic          done_q;
    logic          busy_q;
    logic          pass_q;
    logic          fail_q;
    logic          we_q;
    logic          iss_q;

    // Read-tracking pipeline: valid flag and address of each issued read.
    logic [RD_LAT-1:0] pv_q;
    logic [AW-1:0]     pa_q [RD_LAT];

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return DW'(a);
    endfunction

    logic          inv;
    logic          cv;
    logic [AW-1:0] ca;
    logic [DW-1:0] exp_w;
    logic          miss;

    assign inv   = (state_q == T_WR2) || (state_q == T_RD2);
    assign cv    = pv_q[RD_LAT-1];
    assign ca    = pa_q[RD_LAT-1];
    assign exp_w = inv ? ~pat(ca) : pat(ca);
    assign miss  = cv && (bus.ram_q != exp_w);

    always_ff @(posedge clk) begin
        if (ar) begin
            state_q     <= IDLE;
            dout_q      <= '0;
            ram_data_q  <= '0;
            wraddr_q    <= '0;
            rdaddr_q    <= '0;
            fail_addr_q <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            we_q        <= 1'b0;
            iss_q       <= 1'b0;
            pv_q        <= '0;
            for (int i = 0; i < RD_LAT; i++) pa_q[i] <= '0;
        end else begin
            done_q  <= 1'b0;
            pv_q[0] <= iss_q;
            pa_q[0] <= rdaddr_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pa_q[i] <= pa_q[i-1];
            end
            unique case (state_q)
                IDLE: begin
                    if (bus.it) begin
                        state_q    <= T_WR1;
                        busy_q     <= 1'b1;
                        pass_q     <= 1'b0;
                        fail_q     <= 1'b0;
                        we_q       <= 1'b1;
                        wraddr_q   <= '0;
                        ram_data_q <= pat('0);
                    end else if (bus.wr) begin
                        state_q    <= H_WR;
                        busy_q     <= 1'b1;
                        we_q       <= 1'b1;
                        wraddr_q   <= bus.addr;
                        ram_data_q <= bus.din;
                        done_q     <= 1'b1;
                    end else if (bus.rd) begin
                        state_q  <= H_RD;
                        busy_q   <= 1'b1;
                        rdaddr_q <= bus.addr;
                        iss_q    <= 1'b1;
                    end
                end
                H_WR: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    we_q    <= 1'b0;
                end
                H_RD: begin
                    iss_q <= 1'b0;
                    if (cv) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        dout_q  <= bus.ram_q;
                        done_q  <= 1'b1;
                    end
                end
                T_WR1, T_WR2: begin
                    if (wraddr_q == LAST) begin
                        state_q  <= inv ? T_RD2 : T_RD1;
                        we_q     <= 1'b0;
                        rdaddr_q <= '0;
                        iss_q    <= 1'b1;
                    end else begin
                        wraddr_q   <= wraddr_q + 1'b1;
                        ram_data_q <= inv ? ~pat(wraddr_q + 1'b1)
                                          : pat(wraddr_q + 1'b1);
                    end
                end
                T_RD1, T_RD2: begin
                    if (iss_q) begin
                        if (rdaddr_q == LAST) iss_q <= 1'b0;
                        else rdaddr_q <= rdaddr_q + 1'b1;
                    end
                    // First mismatch squashes everything still in flight.
                    if (miss) begin
                        state_q     <= T_END;
                        fail_q      <= 1'b1;
                        fail_addr_q <= ca;
                        done_q      <= 1'b1;
                        iss_q       <= 1'b0;
                        pv_q        <= '0;
                    end else if (cv && ca == LAST) begin
                        if (inv) begin
                            state_q <= T_END;
                            pass_q  <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= T_WR2;
                            we_q       <= 1'b1;
                            wraddr_q   <= '0;
                            ram_data_q <= ~pat('0);
                        end
                    end
                end
                T_END: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.dout       = dout_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;
    assign bus.pass       = pass_q;
    assign bus.fail       = fail_q;
    assign bus.fail_addr  = fail_addr_q;
    assign bus.ram_data   = ram_data_q;
    assign bus.ram_wraddr = wraddr_q;
    assign bus.ram_rdaddr = rdaddr_q;
    assign bus.ram_we     = we_q;
endmodule

// File: tb/tb_dpram_bist_ctrl.sv
// Directed bench for dpram_bist_ctrl: default instance (16/10/1)
// and a small instance (8/4/2), each with its own RAM model.
module tb_dpram_bist_ctrl;
    logic clk = 1'b0;
    logic ar  = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    dpram_bist_ctrl_if #(.DW(16), .AW(10)) ifa ();
    dpram_bist_ctrl_if #(.DW(8),  .AW(4))  ifb ();

    dpram_bist_ctrl #(.DW(16), .AW(10), .RD_LAT(1)) u_a (
        .clk(clk), .ar(ar), .bus(ifa)
    );
    dpram_bist_ctrl #(.DW(8), .AW(4), .RD_LAT(2)) u_b (
        .clk(clk), .ar(ar), .bus(ifb)
    );

    // RAM model A: one-cycle registered read, optional stuck bit 3 at 0x012.
    logic [15:0] mema [1024];
    logic [15:0] qa;
    logic        fault_a = 1'b0;
    always @(posedge clk) begin
        if (ifa.ram_we) mema[ifa.ram_wraddr] <= ifa.ram_data;
        qa <= mema[ifa.ram_rdaddr]
            | ((fault_a && ifa.ram_rdaddr == 10'h012) ? 16'h0008 : 16'h0000);
    end
    assign ifa.ram_q = qa;

    // RAM model B: two-cycle registered read.
    logic [7:0] memb [16];
    logic [7:0] qb1, qb2;
    always @(posedge clk) begin
        if (ifb.ram_we) memb[ifb.ram_wraddr] <= ifb.ram_data;
        qb1 <= memb[ifb.ram_rdaddr];
        qb2 <= qb1;
    end
    assign ifb.ram_q = qb2;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n = 1-based cycle count from acceptance cycle to done cycle.
    task automatic wait_done(input bit sel_b, input int lim, output int n);
        n = 2;
        while (!(sel_b ? ifb.done : ifa.done) && n < lim) begin
            tick();
            n++;
        end
        chk("done_seen", sel_b ? ifb.done : ifa.done, 1);
    endtask

    task automatic host_rd_a(input logic [9:0] a, input logic [15:0] exp,
                             input string tag);
        ifa.rd = 1'b1; ifa.addr = a;
        tick();
        ifa.rd = 1'b0;
        tick();
        chk({tag, "_done_early"}, ifa.done, 0);
        tick();
        chk({tag, "_done"}, ifa.done, 1);
        chk({tag, "_dout"}, ifa.dout, exp);
    endtask

    int n;
    int dn;
    int wes;
    bit found;

    initial begin
        ifa.rd = 0; ifa.wr = 0; ifa.it = 0; ifa.addr = '0; ifa.din = '0;
        ifb.rd = 0; ifb.wr = 0; ifb.it = 0; ifb.addr = '0; ifb.din = '0;
        tick();
        tick();
        ar = 1'b0;
        chk("rst_busy", ifa.busy, 0);
        chk("rst_done", ifa.done, 0);
        chk("rst_we", ifa.ram_we, 0);
        chk("rst_passfail", {ifa.pass, ifa.fail}, 0);
        chk("rst_dout", ifa.dout, 0);
        chk("rst_b_busy", ifb.busy, 0);

        // Small instance: full test length and final contents.
        ifb.it = 1'b1;
        tick();
        ifb.it = 1'b0;
        wait_done(1'b1, 200, n);
        chk("b_len", n, 70);
        chk("b_pass", ifb.pass, 1);
        chk("b_fail", ifb.fail, 0);
        tick();
        chk("b_idle", ifb.busy, 0);
        for (int a = 0; a < 16; a++) begin
            logic [7:0] e;
            e = 8'hFF ^ 8'(a);
            chk($sformatf("b_mem%0d", a), memb[a], e);
        end
        ifb.rd = 1'b1; ifb.addr = 4'h3;
        tick();
        ifb.rd = 1'b0;
        tick();
        tick();
        chk("b_rd_early", ifb.done, 0);
        tick();
        chk("b_rd_done", ifb.done, 1);
        chk("b_rd_dout", ifb.dout, 8'hFC);

        // Host write then read.
        ifa.wr = 1'b1; ifa.addr = 10'h005; ifa.din = 16'hBEEF;
        tick();
        ifa.wr = 1'b0;
        chk("wr_we", ifa.ram_we, 1);
        chk("wr_addr", ifa.ram_wraddr, 10'h005);
        chk("wr_data", ifa.ram_data, 16'hBEEF);
        chk("wr_done", ifa.done, 1);
        chk("wr_busy", ifa.busy, 1);
        tick();
        chk("wr_we_end", ifa.ram_we, 0);
        chk("wr_busy_end", ifa.busy, 0);
        host_rd_a(10'h005, 16'hBEEF, "rd1");
        chk("rd1_busy_end", ifa.busy, 0);

        // Write pulsed while a host read is in flight is ignored.
        ifa.rd = 1'b1; ifa.addr = 10'h005;
        tick();
        ifa.rd = 1'b0;
        ifa.wr = 1'b1; ifa.addr = 10'h007; ifa.din = 16'hAAAA;
        dn = 0; wes = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            ifa.wr = 1'b0;
            dn  += int'(ifa.done);
            wes += int'(ifa.ram_we);
        end
        chk("busy_wr_we", wes, 0);
        chk("busy_wr_done", dn, 1);
        chk("busy_wr_dout", ifa.dout, 16'hBEEF);

        // All requests together: self-test wins.
        ifa.rd = 1'b1; ifa.wr = 1'b1; ifa.it = 1'b1;
        ifa.addr = 10'h005; ifa.din = 16'h1234;
        tick();
        ifa.rd = 1'b0; ifa.wr = 1'b0; ifa.it = 1'b0;
        chk("prio_busy", ifa.busy, 1);
        chk("prio_we", ifa.ram_we, 1);
        chk("prio_addr", ifa.ram_wraddr, 0);
        chk("prio_data", ifa.ram_data, 0);
        chk("prio_done", ifa.done, 0);

        // Reset in the middle of the inverted write pass.
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            tick();
            found = ifa.ram_we && ifa.ram_wraddr == 10'd20 &&
                    ifa.ram_data == 16'hFFEB;
        end
        chk("wr2_reached", found, 1);
        ar = 1'b1;
        tick();
        ar = 1'b0;
        chk("mid_rst_we", ifa.ram_we, 0);
        chk("mid_rst_busy", ifa.busy, 0);
        chk("mid_rst_flags", {ifa.done, ifa.pass, ifa.fail}, 0);
        chk("mid_rst_dout", ifa.dout, 0);
        chk("mid_rst_addrs",
            {ifa.ram_wraddr, ifa.ram_rdaddr, ifa.fail_addr}, 0);
        chk("mid_rst_data", ifa.ram_data, 0);
        wes = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            wes += int'(ifa.ram_we);
        end
        chk("mid_rst_quiet", wes, 0);
        host_rd_a(10'd5, 16'hFFFA, "rd_inv");
        host_rd_a(10'd21, 16'h0015, "rd_nowr");
        host_rd_a(10'd100, 16'h0064, "rd_p1");

        ifa.it = 1'b1;
        tick();
        ifa.it = 1'b0;
        wait_done(1'b0, 5000, n);
        chk("a_len", n, 4 * 1024 + 2 + 2);
        chk("a_pass", ifa.pass, 1);
        chk("a_fail", ifa.fail, 0);
        tick();

        // Stuck-at-1 bit 3 at 0x012 caught in the first read pass.
        fault_a = 1'b1;
        ifa.it = 1'b1;
        tick();
        ifa.it = 1'b0;
        chk("st_clear", {ifa.pass, ifa.fail}, 0);
        wait_done(1'b0, 5000, n);
        chk("st_len", n, 1046);
        chk("st_fail", ifa.fail, 1);
        chk("st_pass", ifa.pass, 0);
        chk("st_addr", ifa.fail_addr, 10'h012);
        wes = int'(ifa.ram_we);
        for (int i = 0; i < 3; i++) begin
            tick();
            wes += int'(ifa.ram_we);
        end
        chk("st_no_we", wes, 0);
        chk("st_idle", ifa.busy, 0);
        chk("st_hold", {ifa.fail, ifa.fail_addr}, {1'b1, 10'h012});
        fault_a = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dpram_bist_ctrl.md
Name: dpram_bist_ctrl

Overview:
- Parametrised successor to the board-level DPRAM controller.
- Arbitrates single host read/write requests onto a simple dual-port RAM (separate read/write address, registered read with configurable latency).
- Adds a built-in two-pass march self-test: address pattern, then inverted pattern, with pass/fail status and capture of the first failing address.
- Sits between the button/switch test unit and the RAM macro.

Parameters:
DW, 16, data width in bits (1..64)
AW, 10, address width; depth = 2**AW
RD_LAT, 1, RAM read latency in cycles from ram_rdaddr to valid ram_q (1..3)

Ports:
clk  in  1  system clock, all logic rising-edge
ar  in  1  reset, synchronous, active-high
rd  in  1  host read request, sampled in IDLE only
wr  in  1  host write request, sampled in IDLE only
it  in  1  start internal self-test, sampled in IDLE only
addr  in  AW  host address
din  in  DW  host write data
dout  out  DW  host read data, registered, held until next read completes
done  out  1  one-cycle pulse at completion of a host read, host write or self-test
busy  out  1  high whenever state != IDLE
pass  out  1  self-test passed; held until next test start or reset
fail  out  1  self-test failed; held until next test start or reset
fail_addr  out  AW  address of first mismatch; valid while fail=1
ram_data  out  DW  RAM write data
ram_wraddr  out  AW  RAM write address
ram_rdaddr  out  AW  RAM read address
ram_we  out  1  RAM write enable
ram_q  in  DW  RAM read data

Behaviour:
- Reset (ar=1 at an edge): state=IDLE; dout, ram_data, ram_wraddr, ram_rdaddr, fail_addr all 0; done, busy, pass, fail, ram_we 0. Takes effect from any state, including mid-test; no further RAM writes after that edge.
- All outputs are registered.
- Request priority in IDLE: it > wr > rd. Requests while busy are ignored (not queued).
- States: IDLE, H_WR, H_RD, T_WR1, T_RD1, T_WR2, T_RD2, T_END.
- Host write, accepted at edge N: H_WR in cycle N+1 with ram_we=1, ram_wraddr=addr, ram_data=din (captured at N), done=1. Returns to IDLE at N+2.
- Host read, accepted at N: ram_rdaddr=addr from cycle N+1. State waits RD_LAT cycles, then dout captures ram_q. dout valid and done=1 in cycle N+2+RD_LAT, then IDLE.
- Pattern: P(a) = a zero-extended to DW, or truncated to a[DW-1:0] when DW<AW.
- Self-test start: clears pass and fail.
  - T_WR1: writes P(a) to every address a=0..2**AW-1, one per cycle.
  - T_RD1: issues reads a=0..2**AW-1, one per cycle. The expected value is delayed through an RD_LAT-deep pipeline and compared with ram_q. The state stays until the last compare drains (RD_LAT extra cycles).
  - T_WR2 / T_RD2: same, with ~P(a).
- Address counter is AW bits. Terminal count is all-ones; the pass ends on it, with no wrap into a new pass.
- First mismatch:
  - latch fail_addr = address of the compared word;
  - set fail=1;
  - abort immediately to T_END, squashing in-flight compares and issuing no further writes.
- T_END: one cycle, done=1. pass=1 if no mismatch occurred. Then IDLE.
- Nominal test length: 4*2**AW + 2*RD_LAT + 2 cycles from acceptance to the done pulse.
- ram_we is 0 in every state except H_WR, T_WR1 and T_WR2.
- it held high continuously: the test restarts only after returning to IDLE, i.e. at most once per done pulse.

Test Plan:
- Reset, then wr with addr=0x005, din=0xBEEF; later rd with addr=0x005 (RD_LAT=1) -> ram_we pulse of exactly 1 cycle; dout=0xBEEF with done in cycle N+3 after rd acceptance; busy low otherwise.
- rd, wr and it asserted together in IDLE -> self-test starts (busy=1, ram_we=1 at address 0); the host write never occurs.
- it with an ideal RAM model, AW=4, DW=8, RD_LAT=2 -> done after 4*16+4+2=70 cycles; pass=1, fail=0; RAM holds ~P(a) at every address.
- it with RAM model bit 3 stuck-at-1 at address 0x012 (default params) -> fail=1, fail_addr=0x012 during pass 1 (P=0x0012 reads 0x001A); pass=0; no ram_we after the fail edge.
- ar asserted mid T_WR2 -> next cycle: all outputs 0, state IDLE. A subsequent rd returns RAM contents without error; a new it runs to pass=1.
- wr pulsed while busy during a host read -> ignored: no ram_we, no extra done.
